// File: rtl/glb_stream_arbiter.sv
// Round-robin arbiter that merges NUM_REQ ready/valid producer streams onto one GLB write port.
// A grant is locked for a whole burst (in_last or MAX_BURST beats), so bursts never interleave.
module glb_stream_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int MAX_BURST  = 8,
    localparam int PW         = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ-1:0]            in_last,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PW-1:0]                 out_src,
    output logic                          busy,
    output logic [31:0]                   beat_total
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_reg;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   owner_reg;
    logic [7:0]      beat_cnt_reg;
    logic [31:0]     beat_total_reg;

    logic [DATA_WIDTH-1:0] owner_data;
    logic                  owner_valid;
    logic                  owner_last;
    logic                  beat;
    logic                  cap_hit;
    logic                  burst_end;
    logic [PW-1:0]         winner;
    logic [PW-1:0]         next_ptr;

    // First valid requester at or above p, wrapping; scanned downward so the nearest wins.
    function automatic logic [PW-1:0] pick(input logic [NUM_REQ-1:0] v, input logic [PW-1:0] p);
        logic [PW-1:0] w;
        int            idx;
        w = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (v[idx]) w = PW'(idx);
        end
        return w;
    endfunction

    assign winner      = pick(in_valid, ptr_reg);
    assign owner_data  = in_data[owner_reg*DATA_WIDTH +: DATA_WIDTH];
    assign owner_valid = in_valid[owner_reg];
    assign owner_last  = in_last[owner_reg];

    assign busy       = (state_reg == BURST);
    assign out_valid  = busy & owner_valid;
    assign out_data   = busy ? owner_data : '0;
    assign out_src    = owner_reg;
    assign beat_total = beat_total_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign in_ready[gi] = busy && (owner_reg == PW'(gi)) && out_ready;
        end
    endgenerate

    assign beat      = out_valid & out_ready;
    assign cap_hit   = ({1'b0, beat_cnt_reg} + 9'd1) == 9'(MAX_BURST);
    assign burst_end = beat & (owner_last | cap_hit);
    assign next_ptr  = (owner_reg == PW'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            owner_reg      <= '0;
            beat_cnt_reg   <= '0;
            beat_total_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|in_valid) begin
                        owner_reg    <= winner;
                        beat_cnt_reg <= '0;
                        state_reg    <= BURST;
                    end
                end
                BURST: begin
                    if (beat) begin
                        beat_total_reg <= beat_total_reg + 32'd1;
                        if (burst_end) begin
                            state_reg <= IDLE;
                            ptr_reg   <= next_ptr;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 8'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_glb_stream_arbiter.sv
// Directed bench for glb_stream_arbiter: inputs change 1 ns after posedge, outputs are checked 4 ns after.
module tb_glb_stream_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;

    logic              clk;
    logic              rst_n;
    logic [NR*DW-1:0]  in_data;
    logic [NR-1:0]     in_valid;
    logic [NR-1:0]     in_last;
    logic [NR-1:0]     in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_src;
    logic              busy;
    logic [31:0]       beat_total;

    int errors = 0;
    int checks = 0;

    glb_stream_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_src    (out_src),
        .busy       (busy),
        .beat_total (beat_total)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %-14s obs=%h", tag, obs);
        end else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [DW-1:0] d, input logic l);
        in_valid[i]          = v;
        in_data[i*DW +: DW]  = d;
        in_last[i]           = l;
    endtask

    task automatic clear_reqs();
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    // req1 streams words lo..hi as a granted burst; the last one optionally carries in_last.
    task automatic req1_words(input int lo, input int hi, input logic end_last);
        for (int k = lo; k <= hi; k++) begin
            set_req(1, 1'b1, DW'(k), end_last && (k == hi));
            settle();
            check("t3_src", 32'(out_src), 32'd1);
            check("t3_data", 32'(out_data), 32'(k));
            check("t3_ready", 32'(in_ready), 32'b0010);
            step();
        end
    endtask

    logic [6:0] bp_seq;
    int         nb;

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        clear_reqs();
        bp_seq = 7'b1011001;
        nb     = 0;

        // reset values
        #3;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_src", 32'(out_src), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_total", beat_total, 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // single requester, 3-beat burst
        out_ready = 1'b1;
        set_req(0, 1'b1, 16'h0001, 1'b0);
        settle();
        check("t1_idle_valid", 32'(out_valid), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_ready", 32'(in_ready), 32'd0);
        step();
        settle();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_d1", 32'(out_data), 32'h1);
        check("t1_src", 32'(out_src), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready", 32'(in_ready), 32'b0001);
        step();
        set_req(0, 1'b1, 16'h0002, 1'b0);
        settle();
        check("t1_d2", 32'(out_data), 32'h2);
        step();
        set_req(0, 1'b1, 16'h0003, 1'b1);
        settle();
        check("t1_d3", 32'(out_data), 32'h3);
        step();
        set_req(0, 1'b0, 16'h0000, 1'b0);
        settle();
        check("t1_end_busy", 32'(busy), 32'd0);
        check("t1_end_valid", 32'(out_valid), 32'd0);
        check("t1_total", beat_total, 32'd3);

        // contention between req0 and req2, then ptr=3 check
        do_reset();
        out_ready = 1'b1;
        set_req(0, 1'b1, 16'h00A0, 1'b0);
        set_req(2, 1'b1, 16'h00C0, 1'b0);
        settle();
        check("t2_idle_busy", 32'(busy), 32'd0);
        step();
        settle();
        check("t2_src0", 32'(out_src), 32'd0);
        check("t2_a0", 32'(out_data), 32'hA0);
        check("t2_ready0", 32'(in_ready), 32'b0001);
        step();
        set_req(0, 1'b1, 16'h00A1, 1'b1);
        settle();
        check("t2_a1", 32'(out_data), 32'hA1);
        step();
        set_req(0, 1'b0, 16'h0000, 1'b0);
        settle();
        check("t2_dead_busy", 32'(busy), 32'd0);
        check("t2_dead_valid", 32'(out_valid), 32'd0);
        step();
        settle();
        check("t2_src2", 32'(out_src), 32'd2);
        check("t2_c0", 32'(out_data), 32'hC0);
        check("t2_ready2", 32'(in_ready), 32'b0100);
        step();
        set_req(2, 1'b1, 16'h00C1, 1'b1);
        settle();
        check("t2_c1", 32'(out_data), 32'hC1);
        step();
        set_req(2, 1'b0, 16'h0000, 1'b0);
        set_req(0, 1'b1, 16'h00E0, 1'b1);
        set_req(3, 1'b1, 16'h00D0, 1'b1);
        settle();
        check("t2_idle2_busy", 32'(busy), 32'd0);
        step();
        settle();
        check("t2_ptr3_src", 32'(out_src), 32'd3);
        check("t2_d0", 32'(out_data), 32'hD0);
        step();
        clear_reqs();
        settle();
        check("t2_end_busy", 32'(busy), 32'd0);
        check("t2_total", beat_total, 32'd5);
        step();

        // burst cap: req1 streams 20 words, req3 competes
        set_req(1, 1'b1, 16'd1, 1'b0);
        set_req(3, 1'b1, 16'h0031, 1'b0);
        settle();
        check("t3_idle_busy", 32'(busy), 32'd0);
        step();
        req1_words(1, 8, 1'b0);
        set_req(1, 1'b1, 16'd9, 1'b0);
        settle();
        check("t3_cap_idle", 32'(busy), 32'd0);
        step();
        settle();
        check("t3_src3", 32'(out_src), 32'd3);
        check("t3_31", 32'(out_data), 32'h31);
        check("t3_r1_blocked", 32'(in_ready), 32'b1000);
        step();
        set_req(3, 1'b1, 16'h0032, 1'b1);
        settle();
        check("t3_32", 32'(out_data), 32'h32);
        step();
        set_req(3, 1'b0, 16'h0000, 1'b0);
        settle();
        check("t3_idle3_busy", 32'(busy), 32'd0);
        step();
        req1_words(9, 16, 1'b0);
        set_req(1, 1'b1, 16'd17, 1'b0);
        settle();
        check("t3_cap2_idle", 32'(busy), 32'd0);
        step();
        req1_words(17, 20, 1'b1);
        clear_reqs();
        settle();
        check("t3_end_busy", 32'(busy), 32'd0);
        check("t3_total", beat_total, 32'd27);

        // backpressure on a 4-beat burst
        do_reset();
        out_ready = 1'b1;
        set_req(0, 1'b1, 16'h0041, 1'b0);
        settle();
        check("t4_idle_busy", 32'(busy), 32'd0);
        step();
        nb = 0;
        for (int j = 0; j < 7; j++) begin
            out_ready = bp_seq[j];
            set_req(0, 1'b1, 16'(16'h41 + nb), nb == 3);
            settle();
            check("t4_ready", 32'(in_ready), {31'd0, out_ready});
            check("t4_data", 32'(out_data), 32'(16'h41 + nb));
            check("t4_busy", 32'(busy), 32'd1);
            if (out_ready) nb++;
            step();
        end
        out_ready = 1'b1;
        set_req(0, 1'b0, 16'h0000, 1'b0);
        settle();
        check("t4_end_busy", 32'(busy), 32'd0);
        check("t4_total", beat_total, 32'd4);
        step();

        // owner stall: req2 drops valid mid-burst while req0 waits
        set_req(2, 1'b1, 16'h0051, 1'b0);
        set_req(0, 1'b1, 16'h0061, 1'b1);
        settle();
        check("t5_idle_busy", 32'(busy), 32'd0);
        step();
        settle();
        check("t5_src2", 32'(out_src), 32'd2);
        check("t5_51", 32'(out_data), 32'h51);
        step();
        set_req(2, 1'b0, 16'h0000, 1'b0);
        for (int j = 0; j < 5; j++) begin
            settle();
            check("t5_stall_busy", 32'(busy), 32'd1);
            check("t5_stall_src", 32'(out_src), 32'd2);
            check("t5_stall_rdy", 32'(in_ready), 32'b0100);
            check("t5_stall_vld", 32'(out_valid), 32'd0);
            step();
        end
        set_req(2, 1'b1, 16'h0052, 1'b0);
        settle();
        check("t5_52", 32'(out_data), 32'h52);
        step();
        set_req(2, 1'b1, 16'h0053, 1'b1);
        settle();
        check("t5_53", 32'(out_data), 32'h53);
        step();
        set_req(2, 1'b0, 16'h0000, 1'b0);
        settle();
        check("t5_idle2_busy", 32'(busy), 32'd0);
        step();
        settle();
        check("t5_src0", 32'(out_src), 32'd0);
        check("t5_61", 32'(out_data), 32'h61);
        step();
        clear_reqs();
        settle();
        check("t5_end_busy", 32'(busy), 32'd0);
        check("t5_total", beat_total, 32'd8);
        step();

        // reset asserted during beat 3 of a 5-beat burst
        set_req(1, 1'b1, 16'h0071, 1'b0);
        settle();
        check("t6_idle_busy", 32'(busy), 32'd0);
        step();
        for (int k = 0; k < 2; k++) begin
            set_req(1, 1'b1, 16'(16'h71 + k), 1'b0);
            settle();
            check("t6_data", 32'(out_data), 32'(16'h71 + k));
            step();
        end
        set_req(1, 1'b1, 16'h0073, 1'b0);
        #1;
        rst_n = 1'b0;
        #2;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_total", beat_total, 32'd0);
        check("t6_rst_ready", 32'(in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        set_req(1, 1'b0, 16'h0000, 1'b0);
        set_req(0, 1'b1, 16'h0081, 1'b1);
        set_req(3, 1'b1, 16'h0091, 1'b1);
        settle();
        check("t6_idle_busy", 32'(busy), 32'd0);
        step();
        settle();
        check("t6_ptr0_src", 32'(out_src), 32'd0);
        check("t6_81", 32'(out_data), 32'h81);
        step();
        clear_reqs();
        settle();
        check("t6_total", beat_total, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
